// File: rtl/acq_bank_scheduler_pkg.sv
// Shared types and constants for the two-bank acquisition scheduler.
// Optional drop counter is enabled by defining ACQ_DROP_COUNT_EN.
package acq_pkg;

  localparam int DEPTH_DEF = 200;
  localparam int ADDR_W    = 9;
  localparam int BANK_BIT  = 8;
  localparam int IDX_W     = BANK_BIT;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_SWITCH = 3'd2,
    ST_DROP   = 3'd3,
    ST_CLOSE  = 3'd4
  } acq_state_e;

endpackage

// File: rtl/acq_bank_scheduler_if.sv
// Sample-in / memory-write-out bundle of the acquisition scheduler.
// drop_count exists only when ACQ_DROP_COUNT_EN is defined.
interface acq_bank_scheduler_if import acq_pkg::*; #(parameter int DATA_W = 16);

  logic                  trigger;
  logic                  sample_valid;
  logic [DATA_W-1:0]     sample_data;
  logic [1:0]            bank_release;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  bank0_full;
  logic                  bank1_full;
  logic                  memorization_completed;
  logic [IDX_W-1:0]      idx_final;
  logic                  overflow;
  logic [2:0]            state;
`ifdef ACQ_DROP_COUNT_EN
  logic [7:0]            drop_count;
`endif

  modport master (
    output trigger, sample_valid, sample_data, bank_release,
    input  wr_en, wr_addr, wr_data, bank0_full, bank1_full,
    input  memorization_completed, idx_final, overflow, state
`ifdef ACQ_DROP_COUNT_EN
    , input drop_count
`endif
  );

  modport slave (
    input  trigger, sample_valid, sample_data, bank_release,
    output wr_en, wr_addr, wr_data, bank0_full, bank1_full,
    output memorization_completed, idx_final, overflow, state
`ifdef ACQ_DROP_COUNT_EN
    , output drop_count
`endif
  );

endinterface

// File: rtl/acq_bank_scheduler_busy.sv
// Per-bank busy flags: set when a bank is handed to readout, cleared on release.
module acq_bank_busy (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] set_i,
  input  logic [1:0] clr_i,
  output logic [1:0] busy_o
);

  logic [1:0] busy_q;

  // Set has priority so a bank just filled is never lost to a stale release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= 2'b00;
    else       busy_q <= set_i | (busy_q & ~clr_i);
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/acq_bank_scheduler.sv
// Ping-pong bank writer for event-triggered sample capture.
// Define ACQ_DROP_COUNT_EN to add a saturating dropped-sample counter.
//   state  | meaning
//   IDLE   | waiting for trigger
//   WRITE  | storing samples into wr_bank
//   SWITCH | one cycle: bank just filled, flip to the other bank
//   DROP   | target bank still in readout, samples discarded
//   CLOSE  | one cycle: event ended mid-bank, hand bank to readout
module acq_bank_scheduler import acq_pkg::*; #(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  acq_bank_scheduler_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  acq_state_e        state_q, state_d;
  logic              bank_q, bank_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        full_q, full_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  idx_final_q, idx_final_d;
  logic              ovf_q, ovf_d;
  logic              drop;
  logic [1:0]        set_busy, busy, busy_eff;

  acq_bank_busy u_busy (
    .clk    (clk),
    .reset  (reset),
    .set_i  (set_busy),
    .clr_i  (bus.bank_release),
    .busy_o (busy)
  );

  // A release arriving this cycle already frees the bank for the next decision.
  assign busy_eff = busy & ~bus.bank_release;

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    idx_d       = idx_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    full_d      = 2'b00;
    done_d      = 1'b0;
    idx_final_d = idx_final_q;
    drop        = 1'b0;
    set_busy    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (bus.trigger) state_d = busy_eff[bank_q] ? ST_DROP : ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.sample_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {bank_q, idx_q};
          wr_data_d = bus.sample_data;
          if (idx_q == LAST) begin
            full_d[bank_q]   = 1'b1;
            set_busy[bank_q] = 1'b1;
            idx_d            = '0;
            state_d          = ST_SWITCH;
          end else begin
            idx_d = idx_q + 1'b1;
            if (!bus.trigger) state_d = ST_CLOSE;
          end
        end else if (!bus.trigger) begin
          state_d = (idx_q != '0) ? ST_CLOSE : ST_IDLE;
        end
      end
      ST_SWITCH: begin
        drop    = bus.sample_valid;
        bank_d  = ~bank_q;
        state_d = busy_eff[~bank_q] ? ST_DROP : ST_WRITE;
      end
      ST_DROP: begin
        drop = bus.sample_valid;
        if (!bus.trigger)           state_d = ST_IDLE;
        else if (!busy_eff[bank_q]) state_d = ST_WRITE;
      end
      ST_CLOSE: begin
        done_d           = 1'b1;
        idx_final_d      = idx_q - 1'b1;
        set_busy[bank_q] = 1'b1;
        bank_d           = ~bank_q;
        idx_d            = '0;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bank_q      <= 1'b0;
      idx_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      full_q      <= 2'b00;
      done_q      <= 1'b0;
      idx_final_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      idx_q       <= idx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      full_q      <= full_d;
      done_q      <= done_d;
      idx_final_q <= idx_final_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef ACQ_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              drop_cnt_q <= 8'd0;
    else if (drop && drop_cnt_q != 8'hFF)   drop_cnt_q <= drop_cnt_q + 8'd1;
  end

  assign bus.drop_count = drop_cnt_q;
`endif

  assign bus.wr_en                  = wr_en_q;
  assign bus.wr_addr                = wr_addr_q;
  assign bus.wr_data                = wr_data_q;
  assign bus.bank0_full             = full_q[0];
  assign bus.bank1_full             = full_q[1];
  assign bus.memorization_completed = done_q;
  assign bus.idx_final              = idx_final_q;
  assign bus.overflow               = ovf_q;
  assign bus.state                  = state_q;

endmodule

// File: tb/tb_acq_bank_scheduler.sv
// Self-checking bench for acq_bank_scheduler: vector table, directed corner sequences, random run vs reference model.
module tb_acq_bank_scheduler;

  localparam int DEPTH = 200;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  acq_bank_scheduler_if #(.DATA_W(16)) bus();

  acq_bank_scheduler #(.DEPTH(DEPTH), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: modes 0..4 follow the documented state numbering.
  int          m_mode;
  bit          m_bank;
  int          m_fill;
  bit [1:0]    m_busy;
  bit          m_ovf;
  logic [7:0]  m_fin;
  int          m_drops;
  bit          e_we;
  logic [8:0]  e_addr;
  logic [15:0] e_data;
  bit [1:0]    e_full;
  bit          e_done;

  task automatic model_reset();
    m_mode = 0; m_bank = 0; m_fill = 0; m_busy = 0; m_ovf = 0; m_fin = 0; m_drops = 0;
    e_we = 0; e_addr = 0; e_data = 0; e_full = 0; e_done = 0;
  endtask

  task automatic model_step(bit trg, bit sv, logic [15:0] d, bit [1:0] rel);
    bit [1:0] freeb;
    bit [1:0] newly;
    bit       dropped;
    freeb = ~(m_busy & ~rel);
    newly = 0;
    dropped = 0;
    e_we = 0; e_full = 0; e_done = 0;
    if (m_mode == 0) begin
      if (trg) m_mode = freeb[m_bank] ? 1 : 3;
    end else if (m_mode == 1) begin
      if (sv) begin
        e_we = 1; e_addr = {m_bank, 8'(m_fill)}; e_data = d;
        m_fill = m_fill + 1;
        if (m_fill == DEPTH) begin
          e_full[m_bank] = 1; newly[m_bank] = 1; m_fill = 0; m_mode = 2;
        end else if (!trg) m_mode = 4;
      end else if (!trg) m_mode = (m_fill > 0) ? 4 : 0;
    end else if (m_mode == 2) begin
      dropped = sv;
      m_bank = !m_bank;
      m_mode = freeb[m_bank] ? 1 : 3;
    end else if (m_mode == 3) begin
      dropped = sv;
      if (!trg) m_mode = 0;
      else if (freeb[m_bank]) m_mode = 1;
    end else begin
      e_done = 1; m_fin = 8'(m_fill - 1); newly[m_bank] = 1;
      m_bank = !m_bank; m_fill = 0; m_mode = 0;
    end
    if (dropped) begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end
    m_busy = newly | (m_busy & ~rel);
  endtask

  task automatic check_all(string tag);
    bit bad;
    checks++;
    bad = (bus.wr_en !== e_we) || {bus.bank1_full, bus.bank0_full} !== e_full ||
          bus.memorization_completed !== e_done || bus.idx_final !== m_fin ||
          bus.overflow !== m_ovf || bus.state !== 3'(m_mode);
    if (e_we && (bus.wr_addr !== e_addr || bus.wr_data !== e_data)) bad = 1;
`ifdef ACQ_DROP_COUNT_EN
    if (bus.drop_count !== 8'(m_drops)) bad = 1;
`endif
    if (bad) begin
      errors++;
      $display("FAIL model_%s t=%0t: got we=%b addr=%h data=%h full=%b%b done=%b fin=%0d ovf=%b st=%0d; need we=%b addr=%h data=%h full=%b done=%b fin=%0d ovf=%b st=%0d",
               tag, $time, bus.wr_en, bus.wr_addr, bus.wr_data, bus.bank1_full, bus.bank0_full,
               bus.memorization_completed, bus.idx_final, bus.overflow, bus.state,
               e_we, e_addr, e_data, e_full, e_done, m_fin, m_ovf, m_mode);
    end
  endtask

  task automatic expect_eq(string name, logic [31:0] got, logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %0h need %0h", name, got, need);
    end
  endtask

  task automatic step(bit trg, bit sv, logic [15:0] d, bit [1:0] rel, string tag);
    bus.trigger = trg; bus.sample_valid = sv; bus.sample_data = d; bus.bank_release = rel;
    @(posedge clk); #1;
    model_step(trg, sv, d, rel);
    check_all(tag);
  endtask

  task automatic do_reset();
    bus.trigger = 0; bus.sample_valid = 0; bus.sample_data = 0; bus.bank_release = 0;
    reset = 1;
    #2;
    model_reset();
    check_all("reset");
    @(posedge clk); #1;
    reset = 0;
  endtask

  typedef struct {
    bit          trg;
    bit          sv;
    logic [15:0] d;
    bit          we;
    logic [8:0]  addr;
    bit          done;
    logic [7:0]  fin;
    logic [2:0]  st;
  } vec_t;

  vec_t tbl[12];
  bit   trg_r;

  initial begin
    clk = 0;
    reset = 1;
    bus.trigger = 0; bus.sample_valid = 0; bus.sample_data = 0; bus.bank_release = 0;

    // Short event on bank 0, then an event ending with a sample on the falling edge.
    tbl[0]  = '{1, 0, 16'h0000, 0, 9'h000, 0, 8'd0, 3'd1};
    tbl[1]  = '{1, 1, 16'hA001, 1, 9'h000, 0, 8'd0, 3'd1};
    tbl[2]  = '{1, 1, 16'hA002, 1, 9'h001, 0, 8'd0, 3'd1};
    tbl[3]  = '{1, 1, 16'hA003, 1, 9'h002, 0, 8'd0, 3'd1};
    tbl[4]  = '{1, 1, 16'hA004, 1, 9'h003, 0, 8'd0, 3'd1};
    tbl[5]  = '{1, 1, 16'hA005, 1, 9'h004, 0, 8'd0, 3'd1};
    tbl[6]  = '{0, 0, 16'h0000, 0, 9'h000, 0, 8'd0, 3'd4};
    tbl[7]  = '{0, 0, 16'h0000, 0, 9'h000, 1, 8'd4, 3'd0};
    tbl[8]  = '{1, 0, 16'h0000, 0, 9'h000, 0, 8'd4, 3'd1};
    tbl[9]  = '{1, 1, 16'hB001, 1, 9'h100, 0, 8'd4, 3'd1};
    tbl[10] = '{0, 1, 16'hB002, 1, 9'h101, 0, 8'd4, 3'd4};
    tbl[11] = '{0, 0, 16'h0000, 0, 9'h000, 1, 8'd1, 3'd0};

    do_reset();
    expect_eq("rst_wr_en", bus.wr_en, 0);
    expect_eq("rst_state", bus.state, 0);
    expect_eq("rst_overflow", bus.overflow, 0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].trg, tbl[i].sv, tbl[i].d, 2'b00, "tbl");
      expect_eq($sformatf("tbl%0d_we", i), bus.wr_en, tbl[i].we);
      if (tbl[i].we) expect_eq($sformatf("tbl%0d_addr", i), bus.wr_addr, tbl[i].addr);
      expect_eq($sformatf("tbl%0d_done", i), bus.memorization_completed, tbl[i].done);
      expect_eq($sformatf("tbl%0d_fin", i), bus.idx_final, tbl[i].fin);
      expect_eq($sformatf("tbl%0d_state", i), bus.state, tbl[i].st);
    end

    // Fill both banks, drop, then resume after bank 0 release.
    do_reset();
    step(1, 0, 0, 0, "fill");
    for (int i = 0; i < DEPTH; i++) step(1, 1, 16'(i), 0, "fill");
    expect_eq("b0_last_addr", bus.wr_addr, 9'h0C7);
    expect_eq("b0_full", bus.bank0_full, 1);
    expect_eq("b0_full_state", bus.state, 2);
    step(1, 0, 0, 0, "fill");
    expect_eq("after_switch_state", bus.state, 1);
    step(1, 1, 16'h1234, 0, "fill");
    expect_eq("b1_first_addr", bus.wr_addr, 9'h100);
    expect_eq("b1_first_data", bus.wr_data, 16'h1234);
    for (int i = 1; i < DEPTH; i++) step(1, 1, 16'(i + 1000), 0, "fill");
    expect_eq("b1_full", bus.bank1_full, 1);
    expect_eq("b1_last_addr", bus.wr_addr, 9'h1C7);
    step(1, 0, 0, 0, "fill");
    expect_eq("drop_state", bus.state, 3);
    step(1, 1, 16'hDEAD, 0, "drop");
    expect_eq("drop_wr_en", bus.wr_en, 0);
    expect_eq("drop_overflow", bus.overflow, 1);
    step(1, 0, 0, 2'b01, "release");
    expect_eq("release_state", bus.state, 1);
    step(1, 1, 16'h5555, 0, "resume");
    expect_eq("resume_wr_en", bus.wr_en, 1);
    expect_eq("resume_addr", bus.wr_addr, 9'h000);

    // Trigger drops right after a bank fills: no completion pulse.
    do_reset();
    step(1, 0, 0, 0, "edge");
    for (int i = 0; i < DEPTH; i++) step(1, 1, 16'(i), 0, "edge");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, "edge");
      expect_eq("edge_no_done", bus.memorization_completed, 0);
    end
    expect_eq("edge_idle", bus.state, 0);
    step(1, 0, 0, 0, "edge");
    step(1, 1, 16'h7777, 0, "edge");
    expect_eq("edge_next_bank", bus.wr_addr, 9'h100);

    // Asynchronous reset in the middle of a write burst.
    do_reset();
    step(1, 0, 0, 0, "midrst");
    for (int i = 0; i < 57; i++) step(1, 1, 16'(i + 1), 0, "midrst");
    expect_eq("midrst_addr", bus.wr_addr, 9'h038);
    reset = 1;
    #2;
    model_reset();
    check_all("midrst");
    expect_eq("midrst_wr_en", bus.wr_en, 0);
    expect_eq("midrst_addr0", bus.wr_addr, 0);
    expect_eq("midrst_data0", bus.wr_data, 0);
    expect_eq("midrst_state", bus.state, 0);
    @(posedge clk); #1;
    reset = 0;
    step(1, 0, 0, 0, "midrst");
    step(1, 1, 16'h4242, 0, "midrst");
    expect_eq("midrst_restart", bus.wr_addr, 9'h000);

    // Random traffic against the reference model.
    do_reset();
    trg_r = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 59) == 0) trg_r = !trg_r;
      step(trg_r, $urandom_range(0, 9) < 7, 16'($urandom),
           {$urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0}, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
